// File: rtl/nibble_add_seq_if.sv
// Request/result and external 4-bit CPA signals for nibble_add_seq.
// The slave modport is the sequencer; the master modport is its requester plus the CPA.
interface nibble_add_seq_if;
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;

  logic          start;
  logic          sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic [NW-1:0] cpa_a;
  logic [NW-1:0] cpa_b;
  logic          cpa_cin;
  logic [NW-1:0] cpa_s;
  logic          cpa_cout;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  modport slave (
    input  start, sub, a, b, cin, cpa_s, cpa_cout,
    output cpa_a, cpa_b, cpa_cin, busy, done, sum, cout, ovf
  );

  modport master (
    output start, sub, a, b, cin, cpa_s, cpa_cout,
    input  cpa_a, cpa_b, cpa_cin, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_add_seq.sv
// 16-bit add/subtract sequenced LSB-first through an external 4-bit carry-propagate adder.
// All outputs, including the CPA operand drive, are registered.
module nibble_add_seq (
  input  logic            clk,
  input  logic            rst,
  nibble_add_seq_if.slave bus
);
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_eff;
  logic [W-1:0]  acc;
  logic          carry;

  logic          accept_c;
  logic [W-1:0]  b_in_c;
  logic          carry_in_c;
  logic [1:0]    idx_nxt_c;
  logic [W-1:0]  sum_new_c;

  // Subtraction is a + ~b + 1, so the inversion and forced carry happen at capture time.
  assign accept_c   = bus.start && (state == IDLE || state == DONE);
  assign b_in_c     = bus.sub ? ~bus.b : bus.b;
  assign carry_in_c = bus.sub ? 1'b1 : bus.cin;
  assign idx_nxt_c  = idx + 2'd1;
  assign sum_new_c  = {bus.cpa_s, acc[W-NW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      a_reg       <= '0;
      b_eff       <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      bus.cpa_a   <= '0;
      bus.cpa_b   <= '0;
      bus.cpa_cin <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.sum     <= '0;
      bus.cout    <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (accept_c) begin
            state       <= ADD;
            idx         <= 2'd0;
            a_reg       <= bus.a;
            b_eff       <= b_in_c;
            carry       <= carry_in_c;
            bus.busy    <= 1'b1;
            bus.cpa_a   <= bus.a[NW-1:0];
            bus.cpa_b   <= b_in_c[NW-1:0];
            bus.cpa_cin <= carry_in_c;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        ADD: begin
          acc[{idx, 2'b00} +: NW] <= bus.cpa_s;
          carry                   <= bus.cpa_cout;
          idx                     <= idx_nxt_c;
          if (idx == 2'd3) begin
            // Last nibble: publish the whole result at once and release the CPA.
            state       <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.sum     <= sum_new_c;
            bus.cout    <= bus.cpa_cout;
            bus.ovf     <= (a_reg[W-1] == b_eff[W-1]) && (sum_new_c[W-1] != a_reg[W-1]);
            bus.cpa_a   <= '0;
            bus.cpa_b   <= '0;
            bus.cpa_cin <= 1'b0;
          end else begin
            bus.cpa_a   <= a_reg[{idx_nxt_c, 2'b00} +: NW];
            bus.cpa_b   <= b_eff[{idx_nxt_c, 2'b00} +: NW];
            bus.cpa_cin <= bus.cpa_cout;
          end
        end

        default: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.cpa_a   <= '0;
          bus.cpa_b   <= '0;
          bus.cpa_cin <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: behavioural 4-bit CPA, directed vectors, scoreboard-checked results.
module tb_nibble_add_seq;
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   ncmp;
  int   nerr;
  exp_t expq[$];

  nibble_add_seq_if bus ();

  nibble_add_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational CPA.
  assign {bus.cpa_cout, bus.cpa_s} = 5'(bus.cpa_a) + 5'(bus.cpa_b) + 5'(bus.cpa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      ncmp++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_done: got sum 0x%0h, expected no done", bus.sum);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
          nerr++;
          $display("FAIL result: got sum=0x%h cout=%b ovf=%b, expected sum=0x%h cout=%b ovf=%b",
                   bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  // Presents an operation for one edge (E0); returns #1 after E0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic [15:0] esum, input logic ecout,
                       input logic eovf, input bit expect_result);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    if (expect_result) expq.push_back('{sum: esum, cout: ecout, ovf: eovf});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the current one until done rises; bounded.
  task automatic wait_done(input string name, input int exp_edges);
    int k;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin k = i; break; end
    end
    check(name, 32'(k), 32'(exp_edges));
  endtask

  initial begin
    ncmp = 0; nerr = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", {15'd0, bus.sum, bus.cout}, 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_cpa", {23'd0, bus.cpa_a, bus.cpa_b, bus.cpa_cin}, 32'd0);
    rst = 1'b0;

    // Idle without start stays idle.
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_cpa", {23'd0, bus.cpa_a, bus.cpa_b, bus.cpa_cin}, 32'd0);

    // Plain add with latency check.
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    check("add_busy_e0", 32'(bus.busy), 32'd1);
    check("add_cpa_nib0", {23'd0, bus.cpa_a, bus.cpa_b, bus.cpa_cin}, {23'd0, 4'h4, 4'h1, 1'b0});
    wait_done("add_latency", 4);
    check("add_busy_in_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("add_done_pulse", 32'(bus.done), 32'd0);
    check("add_sum_hold", 32'(bus.sum), 32'h2345);
    check("add_cpa_idle", {23'd0, bus.cpa_a, bus.cpa_b, bus.cpa_cin}, 32'd0);

    // Full ripple: carry into nibbles 1..3.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("ripple_cin_n0", 32'(bus.cpa_cin), 32'd0);
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      check($sformatf("ripple_cin_n%0d", n), 32'(bus.cpa_cin), 32'd1);
    end
    wait_done("ripple_latency", 1);

    // Subtract 5 - 7.
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    check("sub_cpa_b0", 32'(bus.cpa_b), 32'h8);
    check("sub_cpa_cin0", 32'(bus.cpa_cin), 32'd1);
    wait_done("sub_latency", 4);

    // Signed overflow, add then subtract; cin=1 on the subtract must be ignored.
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    wait_done("ovf_add_latency", 4);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    wait_done("ovf_sub_latency", 4);
    @(posedge clk); #1;

    // Contention: start at idx=2 ignored, start during DONE accepted.
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.a = 16'hAAAA; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("cont_done", 32'(bus.done), 32'd1);
    bus.a = 16'h0010; bus.b = 16'h0020; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    expq.push_back('{sum: 16'h0030, cout: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_sum_hold", 32'(bus.sum), 32'h0002);
    wait_done("b2b_latency", 4);
    @(posedge clk); #1;

    // Reset at idx=1 aborts without a done pulse.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'h0000);
    check("abort_cpa", {23'd0, bus.cpa_a, bus.cpa_b, bus.cpa_cin}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
    wait_done("post_rst_latency", 4);
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a 16-bit operation; sampled only in IDLE or DONE.
REQ-004 SHALL have port sub, input, 1 bit: 0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
REQ-005 SHALL have ports a and b, input, 16 bits each: operands, sampled with start.
REQ-006 SHALL have port cin, input, 1 bit: carry-in for add; sampled with start.
REQ-007 SHALL have port cpa_a, output, 4 bits: A nibble driven to the external 4-bit CPA.
REQ-008 SHALL have port cpa_b, output, 4 bits: B nibble driven to the CPA, already inverted when sub=1.
REQ-009 SHALL have port cpa_cin, output, 1 bit: carry into the CPA.
REQ-010 SHALL have ports cpa_s (input, 4 bits) and cpa_cout (input, 1 bit): combinational CPA result, settled within one clock period.
REQ-011 SHALL have port busy, output, 1 bit: high in ADD.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-013 SHALL have port sum, output, 16 bits: last completed result.
REQ-014 SHALL have ports cout and ovf, output, 1 bit each: final carry-out and signed overflow of the last result.

Function
REQ-015 SHALL implement FSM states IDLE, ADD, DONE, with a 2-bit nibble index idx used in ADD.
REQ-016 IDLE: start=1 at an edge -> ADD, idx=0; latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin.
REQ-017 IDLE with start=0 SHALL remain in IDLE.
REQ-018 In ADD, outputs SHALL be cpa_a = a_reg[4*idx+3:4*idx], cpa_b = b_eff[4*idx+3:4*idx], cpa_cin = carry.
REQ-019 At each ADD edge: acc[4*idx+3:4*idx] <= cpa_s, carry <= cpa_cout, idx <= idx+1.
REQ-020 The edge with idx=3 SHALL transition to DONE.
REQ-021 Nibble order SHALL be least significant first: idx 0 = bits 3:0, up to idx 3 = bits 15:12.
REQ-022 On entry to DONE: sum <= acc with nibble 3 merged, cout <= final cpa_cout, ovf <= (a_reg[15]==b_eff[15]) && (new sum[15]!=a_reg[15]).
REQ-023 done SHALL be 1 only in DONE.
REQ-024 busy SHALL be 1 only in ADD.
REQ-025 Latency: start sampled at edge E0; busy high E0..E4; done high E4..E5; exactly 4 CPA cycles.
REQ-026 DONE -> IDLE at the next edge, or directly -> ADD if start=1 (back-to-back accepted, new operands latched).
REQ-027 start in ADD SHALL be ignored and SHALL NOT alter latched operands, carry or idx.
REQ-028 Outside ADD, cpa_a, cpa_b and cpa_cin SHALL be driven 0.
REQ-029 sum, cout and ovf SHALL hold their values from DONE until the next DONE or reset; they SHALL NOT show partial results.
REQ-030 All arithmetic SHALL be modulo 2^16; carry beyond bit 15 appears only on cout. With sub=1, cout=1 means no borrow.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, acc=0, and all outputs 0 (busy, done, sum, cout, ovf, cpa_*).
REQ-032 rst SHALL have priority over start and over any in-flight operation.
REQ-033 An operation aborted by reset SHALL produce no done pulse and SHALL NOT update sum.
REQ-034 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-035 Add: a=0x1234, b=0x1111, cin=0, sub=0 -> done 4 edges after start; sum=0x2345, cout=0, ovf=0.
REQ-036 Full ripple: a=0xFFFF, b=0x0001, cin=0 -> cpa_cin=1 on nibbles 1-3; sum=0x0000, cout=1, ovf=0.
REQ-037 Subtract: a=0x0005, b=0x0007, sub=1 -> first cpa_b=0x8, cpa_cin=1; sum=0xFFFE, cout=0, ovf=0.
REQ-038 Overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-039 Contention: start a=0x0001, b=0x0001; pulse start with a=0xAAAA at idx=2 -> ignored; sum=0x0002; start during DONE -> accepted, busy at next edge.
REQ-040 Reset mid-op: rst at idx=1 -> next cycle busy=0, done=0, sum=0x0000; a following start with 0x0003+0x0004 -> sum=0x0007.
